// File: rtl/vedic_mac_pkg.sv
// Shared types and constants for the Vedic multiply-accumulate stage.
package vedic_mac_pkg;

  localparam int OPND_W    = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

endpackage

// File: rtl/vedic_mac_acc_if.sv
// Operand-stream and result-stream handshake bundle for vedic_mac_acc.
interface vedic_mac_acc_if
  import vedic_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [OPND_W-1:0] mul_1;
  logic [OPND_W-1:0] mul_2;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  beat_cnt;
  logic              acc_ovf;

  // Source of operands and sink of results.
  modport master (
    output in_valid, in_last, mul_1, mul_2, out_ready,
    input  in_ready, out_valid, acc_out, beat_cnt, acc_ovf
  );

  // The MAC block itself.
  modport slave (
    input  in_valid, in_last, mul_1, mul_2, out_ready,
    output in_ready, out_valid, acc_out, beat_cnt, acc_ovf
  );

endinterface

// File: rtl/vedic_16x16.sv
// Unsigned 16x16 Urdhva-Tiryagbhyam (vertical-and-crosswise) multiplier.
// Each output column sums the crosswise bit products a[i]&b[k-i]; the
// column sums are then weighted by 2^k and added.
module vedic_16x16
  import vedic_mac_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  localparam int NCOL = 2 * OPND_W - 1;

  logic [NCOL-1:0][4:0] col;

  genvar gi;
  generate
    for (gi = 0; gi < NCOL; gi++) begin : g_col
      localparam int LO = (gi > OPND_W - 1) ? gi - (OPND_W - 1) : 0;
      localparam int HI = (gi < OPND_W - 1) ? gi : OPND_W - 1;
      logic [4:0] s;
      // Crosswise sum of every bit pair whose weights add up to column gi.
      always_comb begin
        s = '0;
        for (int i = LO; i <= HI; i++) begin
          s = s + {4'b0000, a[i] & b[gi-i]};
        end
      end
      assign col[gi] = s;
    end
  endgenerate

  // Weight each column sum by its position and fold into the product.
  always_comb begin
    p = '0;
    for (int k = 0; k < NCOL; k++) begin
      p = p + (PROD_W'(col[k]) << k);
    end
  end

endmodule

// File: rtl/vedic_mac_acc.sv
// Pipelined multiply-accumulate stage: S1 operand register, S2 product
// register fed by vedic_16x16, S3 frame accumulator with result hold.
// Optional feature macro: VEDIC_MAC_SAT_EN (saturating accumulate with
// sticky acc_ovf); without it the accumulator wraps and acc_ovf is 0.
module vedic_mac_acc
  import vedic_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mac_acc_if.slave   bus
);

  mac_state_t        state_q, state_d;

  logic [OPND_W-1:0] a1_q, a1_d, b1_q, b1_d;
  logic              v1_q, v1_d, last1_q, last1_d;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] p2_q, p2_d;
  logic              v2_q, v2_d, last2_q, last2_d;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_out_q, acc_out_d, acc_sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d, beat_cnt_q, beat_cnt_d, cnt_inc;
  logic              ovf_run_q, ovf_run_d, acc_ovf_q, acc_ovf_d;
  logic              add_carry;
  logic              accept;

  // Readiness comes only from registered state, never from out_ready.
  assign accept = bus.in_valid && (state_q == ACCUM);

  // S1: capture the operand pair of an accepted beat.
  always_comb begin
    a1_d    = a1_q;
    b1_d    = b1_q;
    last1_d = last1_q;
    v1_d    = accept;
    if (accept) begin
      a1_d    = bus.mul_1;
      b1_d    = bus.mul_2;
      last1_d = bus.in_last;
    end
  end

  vedic_16x16 u_mul (
    .a (a1_q),
    .b (b1_q),
    .p (prod)
  );

  // S2: register the 32-bit product alongside its valid and last flags.
  always_comb begin
    p2_d    = p2_q;
    last2_d = last2_q;
    v2_d    = v1_q;
    if (v1_q) begin
      p2_d    = prod;
      last2_d = last1_q;
    end
  end

`ifdef VEDIC_MAC_SAT_EN
  logic [ACC_W:0] sum_wide;
  // Saturating add: one extra bit catches the carry, then clamp.
  always_comb begin
    sum_wide  = {1'b0, acc_q} + (ACC_W+1)'(p2_q);
    add_carry = sum_wide[ACC_W];
    acc_sum   = add_carry ? '1 : sum_wide[ACC_W-1:0];
  end
`else
  // Wrapping add modulo 2^ACC_W; no overflow reporting.
  always_comb begin
    acc_sum   = acc_q + ACC_W'(p2_q);
    add_carry = 1'b0;
  end
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  // S3 accumulate/commit and the ACCUM -> DRAIN -> HOLD sequencing.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_run_d  = ovf_run_q;
    acc_out_d  = acc_out_q;
    beat_cnt_d = beat_cnt_q;
    acc_ovf_d  = acc_ovf_q;

    case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   state_d = DRAIN;
      HOLD:    if (bus.out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    if (v2_q) begin
      if (last2_q) begin
        // Final beat: publish the frame and restart the running totals.
        acc_out_d  = acc_sum;
        beat_cnt_d = cnt_inc;
        acc_ovf_d  = ovf_run_q | add_carry;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_run_d  = 1'b0;
        state_d    = HOLD;
      end else begin
        acc_d     = acc_sum;
        cnt_d     = cnt_inc;
        ovf_run_d = ovf_run_q | add_carry;
        // The previous frame's flag drops on this frame's first commit.
        if (cnt_q == '0) acc_ovf_d = 1'b0;
      end
    end
  end

  // State and pipeline registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      a1_q       <= '0;
      b1_q       <= '0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      p2_q       <= '0;
      v2_q       <= 1'b0;
      last2_q    <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_run_q  <= 1'b0;
      acc_out_q  <= '0;
      beat_cnt_q <= '0;
      acc_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      v1_q       <= v1_d;
      last1_q    <= last1_d;
      p2_q       <= p2_d;
      v2_q       <= v2_d;
      last2_q    <= last2_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_run_q  <= ovf_run_d;
      acc_out_q  <= acc_out_d;
      beat_cnt_q <= beat_cnt_d;
      acc_ovf_q  <= acc_ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.acc_out   = acc_out_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Self-checking bench for vedic_mac_acc: directed frames plus randomized
// back-to-back frames against a frame-level arithmetic scoreboard.
module tb_vedic_mac_acc;
  import vedic_mac_pkg::*;

  localparam int AW = 40;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vedic_mac_acc_if #(.ACC_W(AW), .CNT_W(CW)) bus ();
  vedic_mac_acc_if #(.ACC_W(32), .CNT_W(CW)) bus32 ();

  vedic_mac_acc #(.ACC_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vedic_mac_acc #(.ACC_W(32), .CNT_W(CW)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int or_mode  = 1;   // 0: out_ready low, 1: high, 2: random
  int n_pushed = 0;
  int n_popped = 0;

  typedef struct {
    logic [63:0] acc;
    logic [63:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] cur_sum = '0;
  int           cur_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame result from the plain arithmetic total of all products.
  function automatic exp_t frame_result(input logic [127:0] total, input int cnt, input int w);
    exp_t         r;
    logic [127:0] maxv;
    logic [127:0] t;
    maxv  = (128'd1 << w) - 128'd1;
    r.cnt = 64'(cnt % (1 << CW));
`ifdef VEDIC_MAC_SAT_EN
    r.ovf = (total > maxv);
    t     = r.ovf ? maxv : total;
`else
    r.ovf = 1'b0;
    t     = total & maxv;
`endif
    r.acc = t[63:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat on the main DUT, hold it until taken, update the model.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    bit took;
    int n;
    bus.in_valid = 1'b1;
    bus.mul_1    = a;
    bus.mul_2    = b;
    bus.in_last  = last;
    n            = 0;
    took         = 1'b0;
    do begin
      took = bus.in_ready;
      tick();
      n++;
    end while (!took && n < 200);
    if (!took) begin
      check_val("in_accept_timeout", 64'd0, 64'd1);
    end else begin
      cur_sum = cur_sum + 128'(a) * 128'(b);
      cur_cnt++;
      if (last) begin
        exp_q.push_back(frame_result(cur_sum, cur_cnt, AW));
        n_pushed++;
        cur_sum = '0;
        cur_cnt = 0;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'(($urandom >> 3) & 1);
    bus.mul_1    = 16'($urandom);
    bus.mul_2    = 16'($urandom);
  endtask

  task automatic send32(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n;
    bus32.in_valid = 1'b1;
    bus32.mul_1    = a;
    bus32.mul_2    = b;
    bus32.in_last  = last;
    n = 0;
    while (!bus32.in_ready && n < 50) begin tick(); n++; end
    tick();
    bus32.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!bus.out_valid && n < 64) begin tick(); n++; end
    check_val("out_valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  // Sink-side ready pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: every completed result handshake must match the next frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          n_popped++;
          $display("frame %0d: acc_out=0x%0h beat_cnt=%0d acc_ovf=%0d", n_popped,
                   bus.acc_out, bus.beat_cnt, bus.acc_ovf);
          check_val("sb_acc_out", 64'(bus.acc_out), e.acc);
          check_val("sb_beat_cnt", 64'(bus.beat_cnt), e.cnt);
          check_val("sb_acc_ovf", 64'(bus.acc_ovf), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_acc;
    int   len;
    int   n;
    exp_t e32;

    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.mul_1      = '0;
    bus.mul_2      = '0;
    bus32.in_valid  = 1'b0;
    bus32.in_last   = 1'b0;
    bus32.mul_1     = '0;
    bus32.mul_2     = '0;
    bus32.out_ready = 1'b1;

    // Reset state.
    repeat (3) tick();
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_acc_out", 64'(bus.acc_out), 64'd0);
    check_val("rst_beat_cnt", 64'(bus.beat_cnt), 64'd0);
    check_val("rst_acc_ovf", 64'(bus.acc_ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    // Three-beat frame and result latency.
    send_beat(16'd3, 16'd4, 1'b0);
    send_beat(16'd5, 16'd6, 1'b0);
    send_beat(16'd7, 16'd8, 1'b1);
    t_acc = cyc - 1;
    wait_ov();
    check_val("lat_cycles", 64'(cyc - t_acc), 64'd3);
    check_val("f3_acc_out", 64'(bus.acc_out), 64'd98);
    check_val("f3_beat_cnt", 64'(bus.beat_cnt), 64'd3);
    tick();
    check_val("f3_back_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("f3_out_valid_drop", 64'(bus.out_valid), 64'd0);

    // Single-beat frame with the largest operands.
    send_beat(16'hFFFF, 16'hFFFF, 1'b1);
    wait_ov();
    check_val("max1_acc_out", 64'(bus.acc_out), 64'hFFFE0001);
    check_val("max1_beat_cnt", 64'(bus.beat_cnt), 64'd1);
    check_val("max1_acc_ovf", 64'(bus.acc_ovf), 64'd0);
    tick();

    // Result stalled for 10 cycles while a source keeps offering a beat.
    or_mode = 0;
    tick();
    send_beat(16'd10, 16'd10, 1'b0);
    send_beat(16'd20, 16'd20, 1'b1);
    wait_ov();
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.mul_1    = 16'hABCD;
    bus.mul_2    = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      check_val("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("stall_acc_out", 64'(bus.acc_out), 64'd500);
      check_val("stall_beat_cnt", 64'(bus.beat_cnt), 64'd2);
      check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    or_mode = 1;
    tick();
    tick();
    check_val("stall_release_in_ready", 64'(bus.in_ready), 64'd1);
    send_beat(16'd2, 16'd5, 1'b1);
    wait_ov();
    check_val("post_stall_acc_out", 64'(bus.acc_out), 64'd10);
    check_val("post_stall_beat_cnt", 64'(bus.beat_cnt), 64'd1);
    tick();

    // Narrow accumulator: two maximal products overflow 32 bits.
    send32(16'hFFFF, 16'hFFFF, 1'b0);
    send32(16'hFFFF, 16'hFFFF, 1'b1);
    n = 0;
    while (!bus32.out_valid && n < 64) begin tick(); n++; end
    e32 = frame_result(128'd2 * 128'hFFFE0001, 2, 32);
    check_val("w32_out_valid", 64'(bus32.out_valid), 64'd1);
    check_val("w32_acc_out", 64'(bus32.acc_out), e32.acc);
    check_val("w32_acc_ovf", 64'(bus32.acc_ovf), 64'(e32.ovf));
    check_val("w32_beat_cnt", 64'(bus32.beat_cnt), e32.cnt);
    tick();
    tick();

    // Reset in the middle of a frame, then a clean one-beat frame.
    send_beat(16'd100, 16'd200, 1'b0);
    send_beat(16'd300, 16'd400, 1'b0);
    rst_n = 1'b0;
    #1;
    cur_sum = '0;
    cur_cnt = 0;
    check_val("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("midrst_acc_out", 64'(bus.acc_out), 64'd0);
    check_val("midrst_beat_cnt", 64'(bus.beat_cnt), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_beat(16'd2, 16'd3, 1'b1);
    wait_ov();
    check_val("after_rst_acc_out", 64'(bus.acc_out), 64'd6);
    check_val("after_rst_beat_cnt", 64'(bus.beat_cnt), 64'd1);
    tick();

    // Randomized back-to-back frames with random source gaps and sink stalls.
    or_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(1, 12));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) tick();
        end
        if ($urandom_range(0, 4) == 0)
          send_beat(16'hFFFF - 16'($urandom_range(0, 3)), 16'hFFFF, (b == len - 1));
        else
          send_beat(16'($urandom), 16'($urandom), (b == len - 1));
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    or_mode = 1;
    tick();
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    check_val("sb_frame_count", 64'(n_popped), 64'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vedic_mac_acc.md
# vedic_mac_acc

Pipelined multiply-accumulate stage built around the unsigned 16x16 Vedic multiplier `vedic_16x16`. It accepts a stream of operand pairs over a valid/ready handshake, registers each 32-bit product, and accumulates the frame into a wide accumulator. On the beat flagged `in_last` it emits the frame sum and the beat count over a second valid/ready handshake. It sits directly downstream of the multiplier and feeds the filter/dot-product logic.

## Interface
- `ACC_W`, 40: accumulator and result width; legal range is 32 to 64.
- `CNT_W`, 16: beat counter width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_last`  in  1  final beat of the frame; qualified by `in_valid && in_ready`.
- `mul_1`  in  16  unsigned operand A.
- `mul_2`  in  16  unsigned operand B.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `acc_out`  out  ACC_W  frame sum.
- `beat_cnt`  out  CNT_W  beats in the frame; wraps modulo 2^CNT_W.
- `acc_ovf`  out  1  sticky overflow flag for the frame.

## Operation
- FSM states:
  - ACCUM, the reset state: `in_ready`=1.
  - DRAIN: entered on acceptance of a beat with `in_last`=1. `in_ready`=0.
  - HOLD: entered when the last beat commits to the output register. `out_valid`=1.
  - HOLD returns to ACCUM when `out_valid && out_ready`.
- `in_ready` is decoded only from registered state (`state==ACCUM`). It never depends combinationally on `out_ready`.
- S1 (operand register): on acceptance, latch `mul_1`, `mul_2`, `in_last` and set v1. Otherwise v1 clears.
- S2 (product register): latch the product of the S1 operands from `vedic_16x16`, plus v2/last2.
- S3 (accumulate), when v2:
  - `acc` <= `acc` + zero-extend(p2).
  - `cnt` <= `cnt` + 1.
  - If last2: `acc_out` <= `acc` + p2, `beat_cnt` <= `cnt` + 1, `acc`/`cnt` cleared to 0, state moves to HOLD.
- Arithmetic is unsigned throughout. The product is always exactly 32 bits.
- `acc_out`, `beat_cnt` and `acc_ovf` hold stable while HOLD is stalled.
- Single-beat frame (first beat has `in_last`=1): `acc_out`=product, `beat_cnt`=1.
- Reset mid-frame: all pipeline valids, `acc`, `cnt` and outputs clear at once; the partial frame is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `acc_out`=0, `beat_cnt`=0, `acc_ovf`=0, state ACCUM.
- Throughput: one beat per cycle within a frame. The DRAIN/HOLD gap costs at least 3 idle cycles between frames.
- Latency: last beat accepted in cycle T; `out_valid` high from cycle T+3.
- `out_ready` high with `out_valid` in cycle T+3: ACCUM in T+4, `in_ready`=1 in T+4.
- `out_ready` low: HOLD persists indefinitely. No beats are accepted and no data is lost.
- `in_valid` while `in_ready`=0: ignored. The source must hold its beat.

## Configuration
- `VEDIC_MAC_SAT_EN` defined:
  - The S3 add is computed at ACC_W+1 bits.
  - On carry-out the accumulator clamps to 2^ACC_W-1 and `acc_ovf` sets.
  - `acc_ovf` is sticky to the end of the frame, is presented with `acc_out`, and clears on the next frame's first S3 commit.
- Not defined: the accumulator wraps modulo 2^ACC_W and `acc_ovf` is tied to 0.

## Structure
- Package `vedic_mac_pkg` holds:
  - the state enum typedef `mac_state_t` (ACCUM, DRAIN, HOLD);
  - constant `PROD_W`=32;
  - default constants for `ACC_W` and `CNT_W`.
- One sub-module instance, `vedic_16x16`, unmodified, between S1 and S2. All other logic is local.

## Test plan
- Frame of 3 beats (3x4, 5x6, 7x8, last on the third) with `out_ready`=1 -> `acc_out`=98, `beat_cnt`=3, `out_valid` exactly 3 cycles after the last acceptance.
- Single-beat frame 0xFFFF x 0xFFFF -> `acc_out`=0xFFFE0001, `beat_cnt`=1.
- `out_ready` low for 10 cycles after a result -> `out_valid`, `acc_out` and `beat_cnt` stable, `in_ready`=0 throughout; next frame starts cleanly from 0.
- ACC_W=32, two beats of 0xFFFF x 0xFFFF:
  - with `VEDIC_MAC_SAT_EN` -> `acc_out`=0xFFFFFFFF, `acc_ovf`=1;
  - without -> `acc_out`=0xFFFC0002, `acc_ovf`=0.
- `rst_n` pulsed low mid-frame after 2 beats, then 1-beat frame 2x3 -> `acc_out`=6, `beat_cnt`=1; no stale sum.
- Random `in_valid`/`out_ready` back-to-back frames versus a scoreboard -> every frame sum and count matches and no beat is duplicated or dropped.
